// File: rtl/denise_bpl_shifter.sv
// denise_bpl_shifter: Denise bitplane serializer.
// Holds BPLxDAT words, parallel-loads them into per-plane shift registers,
// serializes at lores/hires/shres rate and delays each playfield by BPLCON1.
// Optional feature macro: DENISE_SHRES_EN (super-hires rate, 64-bit delay line).
module denise_bpl_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        sol,
    input  logic        hires,
    input  logic        shres,
    input  logic [3:0]  bpu,
    input  logic [7:0]  bplcon1,
    input  logic [15:0] data_in,
    input  logic [8:1]  bpldat_wr,
    output logic [8:1]  bpldata
);

`ifdef DENISE_SHRES_EN
    localparam int unsigned DLW = 64;
`else
    localparam int unsigned DLW = 32;
`endif
    localparam int unsigned IW = $clog2(DLW);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     ph;
    logic           shres_m;
    logic           se;
    logic           load;
    logic [15:0]    hold  [1:8];
    logic [15:0]    shift [1:8];
    logic [DLW-1:0] dl    [1:8];
    logic [3:0]     scr   [1:8];
    logic [5:0]     dly   [1:8];
    logic [IW-1:0]  tap   [1:8];
    logic [8:1]     pix;

`ifdef DENISE_SHRES_EN
    assign shres_m = shres;
`else
    logic unused_shres;
    assign unused_shres = shres;
    assign shres_m      = 1'b0;
`endif

    // Shift enable derived from the free-running pixel phase
    always_comb begin
        if (shres_m)    se = 1'b1;
        else if (hires) se = ph[0];
        else            se = (ph == 2'd3);
    end

    // Phase counter and load FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph    <= '0;
            state <= IDLE;
        end else begin
            ph    <= sol ? 2'd0 : ph + 2'd1;
            state <= state_nxt;
        end
    end

    // Load FSM: the load clk is the ARMED exit on se with ph==3, so the
    // transfer and the last-bit shift of the previous word share one edge
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        if (sol) begin
            state_nxt = bpldat_wr[1] ? ARMED : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bpldat_wr[1]) state_nxt = ARMED;
                end
                ARMED: begin
                    if (se && (ph == 2'd3)) begin
                        load      = 1'b1;
                        state_nxt = bpldat_wr[1] ? ARMED : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Holding registers written from the custom bus; sol leaves them intact
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned n = 1; n <= 8; n++) hold[n] <= '0;
        end else begin
            for (int unsigned n = 1; n <= 8; n++) begin
                if (bpldat_wr[n]) hold[n] <= data_in;
            end
        end
    end

    // Per-plane scroll delay in se periods and its delay-line tap
    always_comb begin
        for (int unsigned n = 1; n <= 8; n++) begin
            scr[n] = ((n % 2) == 1) ? bplcon1[3:0] : bplcon1[7:4];
            if (shres_m)    dly[n] = {scr[n], 2'b00};
            else if (hires) dly[n] = {1'b0, scr[n], 1'b0};
            else            dly[n] = {2'b00, scr[n]};
            tap[n] = IW'(dly[n] - 6'd1);
        end
    end

    // Next pixel vector: undelayed MSB or delay-line tap, planes above bpu masked
    always_comb begin
        pix = '0;
        for (int unsigned n = 1; n <= 8; n++) begin
            if (n <= 32'(bpu)) begin
                pix[n] = (dly[n] == 6'd0) ? shift[n][15] : dl[n][tap[n]];
            end
        end
    end

    // Shift registers, delay lines and registered output, advanced on se
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned n = 1; n <= 8; n++) begin
                shift[n] <= '0;
                dl[n]    <= '0;
            end
            bpldata <= '0;
        end else if (sol) begin
            for (int unsigned n = 1; n <= 8; n++) begin
                shift[n] <= '0;
                dl[n]    <= '0;
            end
            bpldata <= '0;
        end else if (se) begin
            for (int unsigned n = 1; n <= 8; n++) begin
                shift[n] <= load ? hold[n] : {shift[n][14:0], 1'b0};
                dl[n]    <= {dl[n][DLW-2:0], shift[n][15]};
            end
            bpldata <= pix;
        end
    end

endmodule
